// File: rtl/bcd_pkg.sv
// Shared definitions for the binary<->BCD converter pair.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int BCD_MAX_DIGIT = 9;
  localparam int ADJ           = 3;

  // Decimal digits needed to hold any w-bit value: ceil(w/3).
  function automatic int bcd_digits(input int w);
    return (w + 2) / 3;
  endfunction

endpackage

// File: rtl/bcd_to_binary_if.sv
// Start/done conversion handshake shared with the forward double_dabble block.
interface bcd_to_binary_if #(
  parameter int W = 8,
  parameter int D = bcd_pkg::bcd_digits(W)
);
  // Handshake: master raises start with bcd stable and holds it until done=1,
  // then drops start for at least one edge. binary/err are valid while done=1.
  logic             start;
  logic [4*D-1:0]   bcd;
  logic             busy;
  logic             done;
  logic [W-1:0]     binary;
  logic             err;

  modport master (output start, bcd, input busy, done, binary, err);
  modport slave  (input start, bcd, output busy, done, binary, err);
endinterface

// File: rtl/bcd_digit_sub3.sv
// Reverse double-dabble cell: subtract 3 from a BCD digit field that is >= 8.
module bcd_digit_sub3
  import bcd_pkg::*;
(
  input  logic [3:0] d,
  output logic [3:0] q
);

  assign q = (d >= 4'd8) ? (d - 4'(ADJ)) : d;

endmodule

// File: rtl/bcd_to_binary.sv
// Sequential BCD-to-binary converter: W shift-right/subtract-3 iterations.
module bcd_to_binary
  import bcd_pkg::*;
#(
  parameter int W = 8
) (
  input  logic      clk,
  input  logic      rst,
  bcd_to_binary_if.slave bus,
  output state_t    state
);

  localparam int D  = bcd_digits(W);
  localparam int SW = 4 * D + W;
  localparam int CW = $clog2(W + 1);

  state_t          state_q, state_d;
  logic [SW-1:0]   sreg;
  logic [CW-1:0]   cnt;
  logic [W-1:0]    bin_q;
  logic            err_q;
  logic            invalid;
  logic            last_iter;
  logic [SW-1:0]   sh;
  logic [4*D-1:0]  adj_dig;
  logic [SW-1:0]   adj;

  always_comb begin
    invalid = 1'b0;
    for (int k = 0; k < D; k++) begin
      if (bus.bcd[4*k +: 4] > 4'(BCD_MAX_DIGIT)) invalid = 1'b1;
    end
  end

  assign sh = sreg >> 1;

  for (genvar k = 0; k < D; k++) begin : g_digit
    bcd_digit_sub3 u_sub (
      .d (sh[W + 4*k +: 4]),
      .q (adj_dig[4*k +: 4])
    );
  end

  assign adj       = {adj_dig, sh[W-1:0]};
  assign last_iter = (cnt == CW'(W - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.start) state_d = invalid ? DONE : CONV;
      CONV: if (last_iter) state_d = DONE;
      DONE: if (!bus.start) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sreg  <= '0;
      cnt   <= '0;
      bin_q <= '0;
      err_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.start) begin
          if (invalid) begin
            // Bad digit: report immediately, no iterations.
            bin_q <= '0;
            err_q <= 1'b1;
          end else begin
            sreg <= {bus.bcd, {W{1'b0}}};
            cnt  <= '0;
          end
        end
        CONV: begin
          sreg <= adj;
          cnt  <= cnt + 1'b1;
          if (last_iter) begin
            // Leftover BCD content means the value did not fit in W bits.
            bin_q <= adj[W-1:0];
            err_q <= |adj[SW-1:W];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy   = (state_q == CONV);
  assign bus.done   = (state_q == DONE);
  assign bus.binary = bin_q;
  assign bus.err    = err_q;
  assign state      = state_q;

endmodule

// File: tb/tb_bcd_to_binary.sv
// Directed bench for bcd_to_binary (W=8): values, errors, handshake, reset, round trip.
module tb_bcd_to_binary;
  import bcd_pkg::*;

  localparam int W = 8;

  logic   clk;
  logic   rst;
  state_t state;
  int     checks;
  int     errors;
  logic [31:0] exp_q[$];

  bcd_to_binary_if #(.W(W)) bus ();

  bcd_to_binary #(.W(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .state (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Raise start, wait for done (bounded), check latency/result/busy, then release.
  task automatic do_conv(input string tag, input logic [11:0] v, input logic [7:0] exp_bin,
                         input logic exp_err, input int exp_lat);
    int edges;
    int busy_cnt;
    edges    = 0;
    busy_cnt = 0;
    exp_q.push_back(32'(exp_bin));
    exp_q.push_back(32'(exp_err));
    bus.bcd   = v;
    bus.start = 1'b1;
    while (!bus.done && edges < 40) begin
      step();
      edges++;
      if (bus.busy) busy_cnt++;
    end
    check({tag, "_latency"}, 32'(edges), 32'(exp_lat));
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_lat - 1));
    check({tag, "_binary"}, 32'(bus.binary), exp_q.pop_front());
    check({tag, "_err"}, 32'(bus.err), exp_q.pop_front());
    bus.start = 1'b0;
    step();
    check({tag, "_done_clear"}, 32'(bus.done), 32'd0);
    check({tag, "_binary_hold"}, 32'(bus.binary), 32'(exp_bin));
  endtask

  function automatic logic [11:0] to_bcd(input int i);
    logic [3:0] h, t, o;
    h = 4'(i / 100);
    t = 4'((i / 10) % 10);
    o = 4'(i % 10);
    return {h, t, o};
  endfunction

  initial begin
    int edges;
    checks    = 0;
    errors    = 0;
    rst       = 1'b0;
    bus.start = 1'b0;
    bus.bcd   = '0;
    #1;
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_err", 32'(bus.err), 32'd0);
    check("reset_binary", 32'(bus.binary), 32'd0);
    check("reset_state", 32'(state), 32'(IDLE));
    step();
    step();
    rst = 1'b1;
    step();

    // basic and boundary values
    do_conv("v042", 12'h042, 8'd42, 1'b0, 9);
    do_conv("v000", 12'h000, 8'd0, 1'b0, 9);
    do_conv("v255", 12'h255, 8'd255, 1'b0, 9);
    do_conv("v256", 12'h256, 8'd0, 1'b1, 9);
    do_conv("v999", 12'h999, 8'd231, 1'b1, 9);

    // invalid digits: one-edge DONE, busy never set
    do_conv("inv0a5", 12'h0A5, 8'd0, 1'b1, 1);
    do_conv("inv00f", 12'h00F, 8'd0, 1'b1, 1);
    do_conv("v100", 12'h100, 8'd100, 1'b0, 9);
    do_conv("inva00", 12'hA00, 8'd0, 1'b1, 1);

    // asynchronous reset mid-conversion after a result with err=1 is held
    do_conv("v999b", 12'h999, 8'd231, 1'b1, 9);
    bus.bcd   = 12'h123;
    bus.start = 1'b1;
    step();
    step();
    step();
    step();
    check("pre_reset_busy", 32'(bus.busy), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_busy", 32'(bus.busy), 32'd0);
    check("async_rst_done", 32'(bus.done), 32'd0);
    check("async_rst_err", 32'(bus.err), 32'd0);
    check("async_rst_binary", 32'(bus.binary), 32'd0);
    check("async_rst_state", 32'(state), 32'(IDLE));
    bus.start = 1'b0;
    step();
    rst = 1'b1;
    step();
    do_conv("v077", 12'h077, 8'd77, 1'b0, 9);

    // start held through DONE: no restart, result stable
    bus.bcd   = 12'h042;
    bus.start = 1'b1;
    edges     = 0;
    while (!bus.done && edges < 40) begin
      step();
      edges++;
    end
    check("hold_latency", 32'(edges), 32'd9);
    for (int c = 0; c < 5; c++) begin
      step();
      check("hold_done", 32'(bus.done), 32'd1);
      check("hold_busy", 32'(bus.busy), 32'd0);
      check("hold_binary", 32'(bus.binary), 32'd42);
    end
    bus.start = 1'b0;
    step();
    check("hold_release", 32'(bus.done), 32'd0);
    step();

    // start dropped and bcd changed mid-CONV: latched operand, one-cycle DONE
    bus.bcd   = 12'h150;
    bus.start = 1'b1;
    step();
    step();
    step();
    bus.start = 1'b0;
    bus.bcd   = 12'h999;
    edges     = 3;
    while (!bus.done && edges < 40) begin
      step();
      edges++;
    end
    check("drop_latency", 32'(edges), 32'd9);
    check("drop_binary", 32'(bus.binary), 32'd150);
    check("drop_err", 32'(bus.err), 32'd0);
    step();
    check("drop_done_one_cycle", 32'(bus.done), 32'd0);
    check("drop_no_restart", 32'(bus.busy), 32'd0);
    step();

    // round trip: decimal encoding of every 8-bit value
    for (int i = 0; i < 256; i++) begin
      do_conv("roundtrip", to_bcd(i), 8'(i), 1'b0, 9);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
